// File: rtl/cpsr_pkg.sv
// Shared mode encodings, status bit positions and SPSR bank helpers
// for the CPSR/SPSR register file.
package cpsr_pkg;

   typedef enum logic [4:0] {
      MODE_USR = 5'b10000,
      MODE_FIQ = 5'b10001,
      MODE_IRQ = 5'b10010,
      MODE_SVC = 5'b10011,
      MODE_ABT = 5'b10111,
      MODE_UND = 5'b11011,
      MODE_SYS = 5'b11111
   } mode_e;

   localparam int BIT_N = 31;
   localparam int BIT_Z = 30;
   localparam int BIT_C = 29;
   localparam int BIT_V = 28;
   localparam int BIT_I = 7;
   localparam int BIT_F = 6;
   localparam int BIT_T = 5;

   localparam int SPSR_BANKS = 5;

   function automatic logic mode_is_legal(input logic [4:0] m);
      case (m)
         MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
         MODE_ABT, MODE_UND, MODE_SYS: mode_is_legal = 1'b1;
         default:                      mode_is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic mode_has_spsr(input logic [4:0] m);
      case (m)
         MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: mode_has_spsr = 1'b1;
         default:                                          mode_has_spsr = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] bank_idx(input logic [4:0] m);
      case (m)
         MODE_FIQ: bank_idx = 3'd0;
         MODE_IRQ: bank_idx = 3'd1;
         MODE_SVC: bank_idx = 3'd2;
         MODE_ABT: bank_idx = 3'd3;
         MODE_UND: bank_idx = 3'd4;
         default:  bank_idx = 3'd0;
      endcase
   endfunction

   // Bit 3 of the mask enables [31:24], bit 0 enables [7:0].
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (mask[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/spsr_bank.sv
// Five banked SPSRs with byte-masked write and mode-indexed combinational read.
// Writes land on the next rising edge; non-SPSR modes write nothing and read 0.
module spsr_bank
   import cpsr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  wr_mode_i,
   input  logic [3:0]  mask_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rd_mode_i,
   output logic [31:0] rdata_o
);

   logic [31:0] bank_q [SPSR_BANKS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SPSR_BANKS; i++) bank_q[i] <= '0;
      end else if (we_i && mode_has_spsr(wr_mode_i)) begin
         bank_q[bank_idx(wr_mode_i)] <= byte_merge(bank_q[bank_idx(wr_mode_i)], wdata_i, mask_i);
      end
   end

   assign rdata_o = mode_has_spsr(rd_mode_i) ? bank_q[bank_idx(rd_mode_i)] : 32'h0;

endmodule

// File: rtl/cpsr_spsr_bank.sv
// CPSR plus banked SPSRs: masked writes, exception entry/return, decoded outputs.
// All updates are visible one cycle after the strobe edge; no backpressure.
module cpsr_spsr_bank
   import cpsr_pkg::*;
#(
   parameter logic [31:0] RESET_CPSR = 32'h000000D3
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpsr_in,
   input  logic        cpsr_we,
   input  logic        spsr_we,
   input  logic [3:0]  field_mask,
   input  logic        exc_entry,
   input  logic [4:0]  exc_mode,
   input  logic        exc_return,
   output logic [31:0] cpsr_out,
   output logic [31:0] spsr_out,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flag_c,
   output logic        flag_v,
   output logic        irq_dis,
   output logic        fiq_dis,
   output logic        thumb,
   output logic [4:0]  mode,
   output logic        mode_err
);

   logic [31:0] cpsr_q, cpsr_d;
   logic        mode_err_q, mode_err_d;
   logic [4:0]  cur_mode;
   logic [31:0] spsr_rd;
   logic        bank_we;
   logic [4:0]  bank_mode;
   logic [3:0]  bank_mask;
   logic [31:0] bank_wdata;
   logic [3:0]  cw_mask;

   assign cur_mode = cpsr_q[4:0];

   always_comb begin
      cpsr_d     = cpsr_q;
      mode_err_d = 1'b0;
      bank_we    = 1'b0;
      bank_mode  = cur_mode;
      bank_mask  = 4'h0;
      bank_wdata = cpsr_in;
      cw_mask    = 4'h0;

      if (exc_entry) begin
         if (mode_has_spsr(exc_mode)) begin
            bank_we      = 1'b1;
            bank_mode    = exc_mode;
            bank_mask    = 4'hF;
            bank_wdata   = cpsr_q;
            cpsr_d[4:0]  = exc_mode;
            cpsr_d[BIT_I] = 1'b1;
            cpsr_d[BIT_T] = 1'b0;
            if (exc_mode == MODE_FIQ) cpsr_d[BIT_F] = 1'b1;
         end else begin
            mode_err_d = 1'b1;
         end
      end else if (exc_return) begin
         if (mode_has_spsr(cur_mode)) cpsr_d = spsr_rd;
         else                         mode_err_d = 1'b1;
      end else begin
         if (cpsr_we) begin
            // User mode may only touch the flags byte; the mode check applies after that.
            cw_mask = (cur_mode == MODE_USR) ? (field_mask & 4'b1000) : field_mask;
            if (cw_mask[0] && !mode_is_legal(cpsr_in[4:0])) begin
               cw_mask[0] = 1'b0;
               mode_err_d = 1'b1;
            end
            cpsr_d = byte_merge(cpsr_q, cpsr_in, cw_mask);
         end
         if (spsr_we) begin
            bank_we   = 1'b1;
            bank_mask = field_mask;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpsr_q     <= RESET_CPSR;
         mode_err_q <= 1'b0;
      end else begin
         cpsr_q     <= cpsr_d;
         mode_err_q <= mode_err_d;
      end
   end

   spsr_bank u_spsr_bank (
      .clk       (clk),
      .rst       (rst),
      .we_i      (bank_we),
      .wr_mode_i (bank_mode),
      .mask_i    (bank_mask),
      .wdata_i   (bank_wdata),
      .rd_mode_i (cur_mode),
      .rdata_o   (spsr_rd)
   );

   assign cpsr_out = cpsr_q;
   assign spsr_out = spsr_rd;
   assign flag_n   = cpsr_q[BIT_N];
   assign flag_z   = cpsr_q[BIT_Z];
   assign flag_c   = cpsr_q[BIT_C];
   assign flag_v   = cpsr_q[BIT_V];
   assign irq_dis  = cpsr_q[BIT_I];
   assign fiq_dis  = cpsr_q[BIT_F];
   assign thumb    = cpsr_q[BIT_T];
   assign mode     = cpsr_q[4:0];
   assign mode_err = mode_err_q;

endmodule

// File: tb/tb_cpsr_spsr_bank.sv
// Directed and random checks of cpsr_spsr_bank against a rule-level reference model.
module tb_cpsr_spsr_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpsr_in;
   logic        cpsr_we, spsr_we, exc_entry, exc_return;
   logic [3:0]  field_mask;
   logic [4:0]  exc_mode;
   logic [31:0] cpsr_out, spsr_out;
   logic        flag_n, flag_z, flag_c, flag_v, irq_dis, fiq_dis, thumb, mode_err;
   logic [4:0]  mode;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: CPSR word plus SPSRs looked up by mode encoding.
   logic [31:0] m_cpsr;
   logic [31:0] m_spsr [logic [4:0]];
   logic        m_err;

   localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010,
                          SVC = 5'b10011, ABT = 5'b10111, UND = 5'b11011, SYS = 5'b11111;

   always #5 clk = ~clk;

   cpsr_spsr_bank #(.RESET_CPSR(32'h000000D3)) dut (
      .clk(clk), .rst(rst), .cpsr_in(cpsr_in), .cpsr_we(cpsr_we), .spsr_we(spsr_we),
      .field_mask(field_mask), .exc_entry(exc_entry), .exc_mode(exc_mode),
      .exc_return(exc_return), .cpsr_out(cpsr_out), .spsr_out(spsr_out),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .irq_dis(irq_dis), .fiq_dis(fiq_dis), .thumb(thumb), .mode(mode), .mode_err(mode_err)
   );

   function automatic bit legal(input logic [4:0] m);
      return m inside {USR, FIQ, IRQ, SVC, ABT, UND, SYS};
   endfunction

   function automatic bit banked(input logic [4:0] m);
      return m inside {FIQ, IRQ, SVC, ABT, UND};
   endfunction

   task automatic model_step(input bit r, input bit cw, input bit sw, input logic [3:0] fm,
                             input logic [31:0] din, input bit ee, input logic [4:0] em,
                             input bit er);
      logic [4:0] cur;
      m_err = 1'b0;
      cur   = m_cpsr[4:0];
      if (r) begin
         m_cpsr = 32'h000000D3;
         foreach (m_spsr[k]) m_spsr[k] = 32'h0;
      end else if (ee) begin
         if (banked(em)) begin
            m_spsr[em] = m_cpsr;
            m_cpsr[4:0] = em;
            m_cpsr[7]   = 1'b1;
            m_cpsr[5]   = 1'b0;
            if (em == FIQ) m_cpsr[6] = 1'b1;
         end else m_err = 1'b1;
      end else if (er) begin
         if (banked(cur)) m_cpsr = m_spsr[cur];
         else m_err = 1'b1;
      end else begin
         if (cw) begin
            for (int b = 0; b < 4; b++) begin
               if (!fm[b]) continue;
               if (cur == USR && b != 3) continue;
               if (b == 0 && !legal(din[4:0])) begin
                  m_err = 1'b1;
                  continue;
               end
               m_cpsr[8*b +: 8] = din[8*b +: 8];
            end
         end
         if (sw && banked(cur)) begin
            for (int b = 0; b < 4; b++)
               if (fm[b]) m_spsr[cur][8*b +: 8] = din[8*b +: 8];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] exp_spsr;
      exp_spsr = banked(m_cpsr[4:0]) ? m_spsr[m_cpsr[4:0]] : 32'h0;
      chk("cpsr_out", cpsr_out, m_cpsr);
      chk("spsr_out", spsr_out, exp_spsr);
      chk("mode_err", {31'h0, mode_err}, {31'h0, m_err});
      chk("decode", {23'h0, flag_n, flag_z, flag_c, flag_v, irq_dis, fiq_dis, thumb, mode},
          {23'h0, m_cpsr[31:28], m_cpsr[7:5], m_cpsr[4:0]});
   endtask

   task automatic cyc(input bit r, input bit cw, input bit sw, input logic [3:0] fm,
                      input logic [31:0] din, input bit ee, input logic [4:0] em, input bit er);
      rst = r; cpsr_we = cw; spsr_we = sw; field_mask = fm; cpsr_in = din;
      exc_entry = ee; exc_mode = em; exc_return = er;
      @(posedge clk);
      model_step(r, cw, sw, fm, din, ee, em, er);
      #1;
      check_all();
   endtask

   logic [4:0] modes_tab [7];

   initial begin
      modes_tab = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS};
      m_cpsr = 32'h0;
      foreach (modes_tab[i]) if (banked(modes_tab[i])) m_spsr[modes_tab[i]] = 32'h0;
      rst = 1'b1; cpsr_we = 0; spsr_we = 0; field_mask = 0; cpsr_in = 0;
      exc_entry = 0; exc_mode = 0; exc_return = 0;
      @(negedge clk);

      // Reset state
      cyc(1, 0, 0, 4'h0, 32'h0, 0, 5'h0, 0);
      chk("rst_cpsr", cpsr_out, 32'h000000D3);
      chk("rst_spsr", spsr_out, 32'h0);
      chk("rst_err", {31'h0, mode_err}, 32'h0);

      // Flags write then IRQ entry
      cyc(0, 1, 0, 4'b1000, 32'hF0000000, 0, 5'h0, 0);
      chk("f_write", cpsr_out, 32'hF00000D3);
      cyc(0, 0, 0, 4'h0, 32'h0, 1, IRQ, 0);
      chk("irq_cpsr", cpsr_out, 32'hF00000D2);
      chk("irq_spsr", spsr_out, 32'hF00000D3);

      // Return, then FIQ entry
      cyc(0, 0, 0, 4'h0, 32'h0, 0, 5'h0, 1);
      chk("ret_cpsr", cpsr_out, 32'hF00000D3);
      cyc(0, 0, 0, 4'h0, 32'h0, 1, FIQ, 0);
      chk("fiq_low", {24'h0, cpsr_out[7:0]}, 32'h000000D1);
      chk("fiq_spsr", spsr_out, 32'hF00000D3);

      // User mode restrictions
      cyc(0, 1, 0, 4'b0001, 32'h00000010, 0, 5'h0, 0);
      cyc(0, 1, 0, 4'b1111, 32'h400000DF, 0, 5'h0, 0);
      chk("usr_cpsr", cpsr_out, 32'h40000010);
      chk("usr_err", {31'h0, mode_err}, 32'h0);
      cyc(0, 0, 0, 4'h0, 32'h0, 0, 5'h0, 1);
      chk("usr_ret", cpsr_out, 32'h40000010);
      chk("usr_ret_err", {31'h0, mode_err}, 32'h1);
      cyc(0, 0, 0, 4'h0, 32'h0, 0, 5'h0, 0);
      chk("err_pulse", {31'h0, mode_err}, 32'h0);

      // Illegal mode write in SVC
      cyc(1, 0, 0, 4'h0, 32'h0, 0, 5'h0, 0);
      cyc(0, 1, 0, 4'b0001, 32'h00000015, 0, 5'h0, 0);
      chk("ill_cpsr", cpsr_out, 32'h000000D3);
      chk("ill_err", {31'h0, mode_err}, 32'h1);
      cyc(0, 1, 0, 4'b1001, 32'h80000015, 0, 5'h0, 0);
      chk("ill_mix", cpsr_out, 32'h800000D3);
      chk("ill_mix_err", {31'h0, mode_err}, 32'h1);

      // Entry outranks writes
      cyc(1, 0, 0, 4'h0, 32'h0, 0, 5'h0, 0);
      cyc(0, 0, 1, 4'hF, 32'h12345678, 0, 5'h0, 0);
      chk("svc_spsr", spsr_out, 32'h12345678);
      cyc(0, 1, 1, 4'hF, 32'hFFFFFFFF, 1, ABT, 0);
      chk("abt_cpsr", cpsr_out, 32'h000000D7);
      chk("abt_spsr", spsr_out, 32'h000000D3);
      cyc(0, 0, 0, 4'h0, 32'h0, 0, 5'h0, 1);
      chk("svc_kept", spsr_out, 32'h12345678);
      cyc(1, 1, 1, 4'hF, 32'hFFFFFFFF, 1, FIQ, 0);
      chk("mid_rst", cpsr_out, 32'h000000D3);
      chk("mid_rst_spsr", spsr_out, 32'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit r, cw, sw, ee, er;
         logic [3:0]  fm;
         logic [31:0] din;
         logic [4:0]  em;
         r   = ($urandom_range(0, 99) == 0);
         ee  = ($urandom_range(0, 9) == 0);
         er  = ($urandom_range(0, 9) == 0);
         cw  = ($urandom_range(0, 2) == 0);
         sw  = ($urandom_range(0, 2) == 0);
         fm  = 4'($urandom);
         din = $urandom;
         if ($urandom_range(0, 3) != 0) din[4:0] = modes_tab[$urandom_range(0, 6)];
         em  = ($urandom_range(0, 4) != 0) ? modes_tab[$urandom_range(0, 6)] : 5'($urandom);
         cyc(r, cw, sw, fm, din, ee, em, er);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
